fetch_queue_unit: RTL and testbench
===================================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, instruction queue entries; power of two, >= 2.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 enable_step_i  input  1  permits issuing new memory requests.
REQ-007 mem_address_o  output  XLEN  fetch address of current request.
REQ-008 get_instruction_o  output  1  memory request valid.
REQ-009 instruction_i  input  32  memory read data.
REQ-010 instruction_completed_i  input  1  one-cycle response strobe; instruction_i valid with it.
REQ-011 redirect_i  input  1  branch/jump redirect, flushes unit.
REQ-012 redirect_pc_i  input  XLEN  new fetch address.
REQ-013 decode_ready_i  input  1  decode accepts head entry this cycle.
REQ-014 instruction_valid_o  output  1  queue head valid.
REQ-015 instruction_to_decode_o  output  32  head instruction.
REQ-016 instruction_pc_o  output  XLEN  PC of head instruction.
REQ-017 queue_count_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-018 fetch_working_info_o  output  1  high while a request is outstanding (states REQUEST or DISCARD).

Function
REQ-019 FSM states IDLE, REQUEST, DISCARD; at most one outstanding memory request.
REQ-020 IDLE -> REQUEST when enable_step_i=1, redirect_i=0, queue_count < DEPTH; get_instruction_o registered, high from next cycle.
REQ-021 In REQUEST, get_instruction_o=1 and mem_address_o=fetch PC held stable until instruction_completed_i=1.
REQ-022 Response in REQUEST (no redirect): push {instruction_i, fetch PC} to queue tail, fetch PC += 4 (modulo 2^XLEN, wraps to 0), get_instruction_o=0 next cycle, go IDLE.
REQ-023 Pushed entry visible at head no earlier than the cycle after the response; no combinational path instruction_i -> instruction_to_decode_o.
REQ-024 Back-to-back: IDLE re-issues the cycle after a response, so one fetch per 2 cycles minimum.
REQ-025 instruction_valid_o = (queue_count != 0); pop when instruction_valid_o and decode_ready_i.
REQ-026 Push and pop in same cycle: count unchanged, FIFO order preserved, read/write pointers wrap modulo DEPTH.
REQ-027 No request issued while queue full; push into full queue cannot occur; pop from empty ignored.
REQ-028 enable_step_i=0: no new request; outstanding request still completes and pushes; pops continue.
REQ-029 redirect_i=1: queue flushed (count=0, instruction_valid_o=0 next cycle), fetch PC <= {redirect_pc_i[XLEN-1:2], 2'b00}; redirect beats simultaneous pop and push.
REQ-030 Redirect in REQUEST without same-cycle response -> DISCARD; get_instruction_o stays high with old address until response, which is dropped; then IDLE.
REQ-031 Redirect with same-cycle response: response dropped, go IDLE.
REQ-032 Redirect in DISCARD: update fetch PC, remain DISCARD.
REQ-033 instruction_completed_i in IDLE is ignored.

Reset
REQ-034 rst_i=1 at clock edge: state IDLE, fetch PC=RESET_PC, queue empty, pointers 0.
REQ-035 During/after reset: get_instruction_o=0, instruction_valid_o=0, queue_count_o=0, fetch_working_info_o=0, instruction_to_decode_o=0, instruction_pc_o=0.
REQ-036 Reset mid-request abandons it; a late response after reset is ignored (IDLE).

Verification
REQ-037 Reset, enable, 1-cycle memory latency, decode_ready_i=1 -> addresses 8000_0000, 8000_0004, 8000_0008 in order; PCs and data match.
REQ-038 decode_ready_i=0, DEPTH=4 -> exactly 4 requests, queue_count_o=4, get_instruction_o stays 0 until a pop.
REQ-039 Redirect to 0x8000_0103 while request outstanding -> old response dropped, next request at 0x8000_0100, queue empty.
REQ-040 Redirect and response same cycle, plus simultaneous pop -> queue empty, no push, next address = redirect target.
REQ-041 RESET_PC=32'hFFFF_FFFC -> second request address 0x0000_0000.
REQ-042 rst_i asserted while REQUEST pending with late response -> all outputs at reset values, response ignored, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-unit bundle: memory request/response, redirect, and the decode-side queue head.
// master = fetch_queue_unit, slave = memory/decode environment.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            enable_step_i;
  logic [XLEN-1:0] mem_address_o;
  logic            get_instruction_o;
  logic [31:0]     instruction_i;
  logic            instruction_completed_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            decode_ready_i;
  logic            instruction_valid_o;
  logic [31:0]     instruction_to_decode_o;
  logic [XLEN-1:0] instruction_pc_o;
  logic [CW-1:0]   queue_count_o;
  logic            fetch_working_info_o;

  modport master (
    input  enable_step_i, instruction_i, instruction_completed_i,
           redirect_i, redirect_pc_i, decode_ready_i,
    output mem_address_o, get_instruction_o, instruction_valid_o,
           instruction_to_decode_o, instruction_pc_o, queue_count_o,
           fetch_working_info_o
  );

  modport slave (
    output enable_step_i, instruction_i, instruction_completed_i,
           redirect_i, redirect_pc_i, decode_ready_i,
    input  mem_address_o, get_instruction_o, instruction_valid_o,
           instruction_to_decode_o, instruction_pc_o, queue_count_o,
           fetch_working_info_o
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a
// DEPTH-entry FIFO of {instruction, pc} toward decode; redirect flushes everything.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int              DEPTH    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQUEST, DISCARD} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_addr;
  logic              req_q;

  entry_t [DEPTH-1:0] q_mem;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              resp;
  logic              redir;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic              not_full;
  logic              issue;
  logic [XLEN-1:0]   redir_pc;

  assign resp     = bus.instruction_completed_i;
  assign redir    = bus.redirect_i;
  assign head_vld = (count != '0);
  assign not_full = (count != CW'(DEPTH));
  // Redirect wins over anything the queue would do this cycle.
  assign push     = (state == REQUEST) && resp && !redir;
  assign pop      = head_vld && bus.decode_ready_i && !redir;
  assign issue    = (state == IDLE) && bus.enable_step_i && !redir && not_full;
  assign redir_pc = bus.redirect_pc_i & ~XLEN'(3);

  // req_addr is held separately from fetch_pc so a redirect during DISCARD
  // keeps the old address on the bus until its response drains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      req_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redir) begin
            fetch_pc <= redir_pc;
          end else if (issue) begin
            state    <= REQUEST;
            req_addr <= fetch_pc;
            req_q    <= 1'b1;
          end
        end
        REQUEST: begin
          if (redir) begin
            fetch_pc <= redir_pc;
            if (resp) begin
              state <= IDLE;
              req_q <= 1'b0;
            end else begin
              state <= DISCARD;
            end
          end else if (resp) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= IDLE;
            req_q    <= 1'b0;
          end
        end
        DISCARD: begin
          if (redir) fetch_pc <= redir_pc;
          if (resp) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || redir) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= '{instr: bus.instruction_i, pc: fetch_pc};
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.mem_address_o           = req_addr;
  assign bus.get_instruction_o       = req_q;
  assign bus.fetch_working_info_o    = req_q;
  assign bus.queue_count_o           = count;
  assign bus.instruction_valid_o     = head_vld;
  // Storage is not reset, so the head is masked while the queue is empty.
  assign bus.instruction_to_decode_o = head_vld ? q_mem[rd_ptr].instr : 32'h0;
  assign bus.instruction_pc_o        = head_vld ? q_mem[rd_ptr].pc : '0;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench: two instances (default RESET_PC and wrap-around RESET_PC),
// memory responses driven by hand with 1-cycle latency.
module tb_fetch_queue_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus_a ();
  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus_b ();

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a.master));

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic respond_a(input logic [31:0] data);
    bus_a.instruction_completed_i = 1'b1;
    bus_a.instruction_i           = data;
    tick();
    bus_a.instruction_completed_i = 1'b0;
    bus_a.instruction_i           = 32'h0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_get"},   64'(bus_a.get_instruction_o), 64'd0);
    chk({tag, "_vld"},   64'(bus_a.instruction_valid_o), 64'd0);
    chk({tag, "_cnt"},   64'(bus_a.queue_count_o), 64'd0);
    chk({tag, "_work"},  64'(bus_a.fetch_working_info_o), 64'd0);
    chk({tag, "_instr"}, 64'(bus_a.instruction_to_decode_o), 64'd0);
    chk({tag, "_pc"},    64'(bus_a.instruction_pc_o), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus_a.enable_step_i = 1'b0; bus_a.instruction_i = '0; bus_a.instruction_completed_i = 1'b0;
    bus_a.redirect_i = 1'b0; bus_a.redirect_pc_i = '0; bus_a.decode_ready_i = 1'b0;
    bus_b.enable_step_i = 1'b0; bus_b.instruction_i = '0; bus_b.instruction_completed_i = 1'b0;
    bus_b.redirect_i = 1'b0; bus_b.redirect_pc_i = '0; bus_b.decode_ready_i = 1'b0;
    tick();
    tick();
    chk_reset_a("reset");

    // Sequential fetch with decode always ready.
    rst = 1'b0;
    bus_a.enable_step_i  = 1'b1;
    bus_a.decode_ready_i = 1'b1;
    tick();
    chk("seq0_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("seq0_addr", 64'(bus_a.mem_address_o), 64'h8000_0000);
    chk("seq0_work", 64'(bus_a.fetch_working_info_o), 64'd1);
    respond_a(32'hA000_0000);
    chk("seq0_vld",   64'(bus_a.instruction_valid_o), 64'd1);
    chk("seq0_instr", 64'(bus_a.instruction_to_decode_o), 64'hA000_0000);
    chk("seq0_pc",    64'(bus_a.instruction_pc_o), 64'h8000_0000);
    chk("seq0_idle",  64'(bus_a.get_instruction_o), 64'd0);
    tick();
    chk("seq1_addr", 64'(bus_a.mem_address_o), 64'h8000_0004);
    chk("seq1_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("seq1_pop",  64'(bus_a.instruction_valid_o), 64'd0);
    respond_a(32'hA000_0001);
    chk("seq1_instr", 64'(bus_a.instruction_to_decode_o), 64'hA000_0001);
    chk("seq1_pc",    64'(bus_a.instruction_pc_o), 64'h8000_0004);
    tick();
    chk("seq2_addr", 64'(bus_a.mem_address_o), 64'h8000_0008);
    respond_a(32'hA000_0002);
    chk("seq2_instr", 64'(bus_a.instruction_to_decode_o), 64'hA000_0002);
    chk("seq2_pc",    64'(bus_a.instruction_pc_o), 64'h8000_0008);
    bus_a.enable_step_i = 1'b0;
    tick();
    chk("dis_get", 64'(bus_a.get_instruction_o), 64'd0);
    chk("dis_vld", 64'(bus_a.instruction_valid_o), 64'd0);

    // Fill the queue with decode stalled.
    bus_a.enable_step_i  = 1'b1;
    bus_a.decode_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_addr", 64'(bus_a.mem_address_o), 64'(32'h8000_000C + 32'(4 * i)));
      respond_a(32'hB000_0000 + 32'(i));
    end
    chk("full_cnt",   64'(bus_a.queue_count_o), 64'd4);
    chk("full_instr", 64'(bus_a.instruction_to_decode_o), 64'hB000_0000);
    chk("full_pc",    64'(bus_a.instruction_pc_o), 64'h8000_000C);
    tick(); tick(); tick();
    chk("full_noreq", 64'(bus_a.get_instruction_o), 64'd0);
    bus_a.decode_ready_i = 1'b1;
    tick();
    bus_a.decode_ready_i = 1'b0;
    chk("pop_cnt",   64'(bus_a.queue_count_o), 64'd3);
    chk("pop_get",   64'(bus_a.get_instruction_o), 64'd0);
    chk("pop_instr", 64'(bus_a.instruction_to_decode_o), 64'hB000_0001);
    tick();
    chk("refill_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("refill_addr", 64'(bus_a.mem_address_o), 64'h8000_001C);

    // Redirect while the request is outstanding: its response must be dropped.
    bus_a.redirect_i    = 1'b1;
    bus_a.redirect_pc_i = 32'h8000_0103;
    tick();
    bus_a.redirect_i = 1'b0;
    chk("rd_cnt",  64'(bus_a.queue_count_o), 64'd0);
    chk("rd_vld",  64'(bus_a.instruction_valid_o), 64'd0);
    chk("rd_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("rd_addr", 64'(bus_a.mem_address_o), 64'h8000_001C);
    chk("rd_work", 64'(bus_a.fetch_working_info_o), 64'd1);
    respond_a(32'hDEAD_BEEF);
    chk("drop_cnt",  64'(bus_a.queue_count_o), 64'd0);
    chk("drop_get",  64'(bus_a.get_instruction_o), 64'd0);
    chk("drop_work", 64'(bus_a.fetch_working_info_o), 64'd0);
    tick();
    chk("rd_new_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("rd_new_addr", 64'(bus_a.mem_address_o), 64'h8000_0100);

    // Redirect with same-cycle response and pop.
    respond_a(32'hC000_0000);
    chk("rp_cnt1", 64'(bus_a.queue_count_o), 64'd1);
    tick();
    chk("rp_addr1", 64'(bus_a.mem_address_o), 64'h8000_0104);
    bus_a.redirect_i              = 1'b1;
    bus_a.redirect_pc_i           = 32'h0000_2000;
    bus_a.instruction_completed_i = 1'b1;
    bus_a.instruction_i           = 32'hC000_0001;
    bus_a.decode_ready_i          = 1'b1;
    tick();
    bus_a.redirect_i              = 1'b0;
    bus_a.instruction_completed_i = 1'b0;
    bus_a.decode_ready_i          = 1'b0;
    chk("rp_cnt", 64'(bus_a.queue_count_o), 64'd0);
    chk("rp_vld", 64'(bus_a.instruction_valid_o), 64'd0);
    chk("rp_get", 64'(bus_a.get_instruction_o), 64'd0);
    tick();
    chk("rp_new_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("rp_new_addr", 64'(bus_a.mem_address_o), 64'h0000_2000);

    // Reset mid-request, then a late response that must be ignored.
    rst = 1'b1;
    tick();
    chk_reset_a("midrst");
    rst = 1'b0;
    bus_a.enable_step_i = 1'b0;
    respond_a(32'hEEEE_0000);
    chk("late_cnt", 64'(bus_a.queue_count_o), 64'd0);
    chk("late_get", 64'(bus_a.get_instruction_o), 64'd0);
    bus_a.enable_step_i = 1'b1;
    tick();
    chk("post_rst_get",  64'(bus_a.get_instruction_o), 64'd1);
    chk("post_rst_addr", 64'(bus_a.mem_address_o), 64'h8000_0000);
    bus_a.enable_step_i = 1'b0;

    // Fetch PC wrap from the top of the address space.
    bus_b.enable_step_i  = 1'b1;
    bus_b.decode_ready_i = 1'b1;
    tick();
    chk("wrap_addr0", 64'(bus_b.mem_address_o), 64'hFFFF_FFFC);
    bus_b.instruction_completed_i = 1'b1;
    bus_b.instruction_i           = 32'h1234_5678;
    tick();
    bus_b.instruction_completed_i = 1'b0;
    chk("wrap_pc0",    64'(bus_b.instruction_pc_o), 64'hFFFF_FFFC);
    chk("wrap_instr0", 64'(bus_b.instruction_to_decode_o), 64'h1234_5678);
    tick();
    chk("wrap_get1",  64'(bus_b.get_instruction_o), 64'd1);
    chk("wrap_addr1", 64'(bus_b.mem_address_o), 64'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
